// File: rtl/accum_pkg.sv
// accum_pkg: shared widths and FSM state encoding for the frame accumulator.
package accum_pkg;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/acc_add16.sv
// acc_add16: combinational 16-bit adder with carry-in and carry-out.
module acc_add16
    import accum_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              ci,
    output logic [DATA_W-1:0] s,
    output logic              co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, ci};
endmodule

// File: rtl/accum_frame_16.sv
// accum_frame_16: sums a framed operand stream, holds the result until consumed.
module accum_frame_16
    import accum_pkg::*;
#(
    parameter int MAX_OPS = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_trunc
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OPS);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nx;
    logic              ovf_q, ovf_d, trunc_q, trunc_d, co, fire, idle, at_max;
    acc_add16 u_add (
        .a  (acc_q),
        .b  (in_data),
        .ci (1'b0),
        .s  (sum),
        .co (co)
    );
    // in_ready depends only on registered state and reset, never on out_ready
    assign in_ready  = rst_n && state_q != HOLD;
    assign out_valid = state_q == HOLD;
    assign out_sum   = out_valid ? acc_q : '0;
    assign out_ovf   = out_valid && ovf_q;
    assign out_count = out_valid ? cnt_q : '0;
    assign out_trunc = out_valid && trunc_q;
    assign fire      = in_valid && in_ready;
    assign idle      = state_q == IDLE;
    assign cnt_nx    = idle ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign at_max    = cnt_nx == MAX_C;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        trunc_d = trunc_q;
        if (state_q == HOLD) begin
            if (out_ready) state_d = IDLE;
        end else if (fire) begin
            acc_d   = idle ? in_data : sum;
            ovf_d   = !idle && (ovf_q || co);
            cnt_d   = cnt_nx;
            trunc_d = at_max && !in_last;
            state_d = (in_last || at_max) ? HOLD : ACCUM;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end
endmodule

// File: doc/accum_frame_16.md
ACCUM_FRAME_16 -- requirements
Module: accum_frame_16

Interface
REQ-001 SHALL have parameter MAX_OPS, default 255, maximum operands per frame (1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand beat offered.
REQ-005 SHALL have port in_ready  output  1  block accepts operand this cycle.
REQ-006 SHALL have port in_data  input  16  unsigned operand.
REQ-007 SHALL have port in_last  input  1  beat is final operand of frame.
REQ-008 SHALL have port out_valid  output  1  frame result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port out_sum  output  16  frame sum modulo 2^16.
REQ-011 SHALL have port out_ovf  output  1  sticky: any carry-out of bit 15 during frame.
REQ-012 SHALL have port out_count  output  8  operands accepted in frame.
REQ-013 SHALL have port out_trunc  output  1  frame closed by MAX_OPS, not in_last.

Function
REQ-014 SHALL implement states IDLE, ACCUM, HOLD; beat accepted when in_valid && in_ready.
REQ-015 SHALL drive in_ready=1 in IDLE and ACCUM, 0 in HOLD.
REQ-016 IDLE, beat accepted: acc <= in_data, ovf <= 0, count <= 1; go ACCUM, or HOLD if in_last or MAX_OPS==1.
REQ-017 ACCUM, beat accepted: {c,acc} <= acc + in_data (17-bit), ovf <= ovf | c, count <= count+1.
REQ-018 ACCUM SHALL go HOLD on the beat with in_last=1 or on the beat making count==MAX_OPS; trunc <= 1 only in the latter case without in_last.
REQ-019 No accepted beat: acc, ovf, count, state unchanged (in_valid gaps allowed anywhere in frame).
REQ-020 out_valid SHALL be 1 exactly in HOLD; out_sum/out_ovf/out_count/out_trunc stable while out_valid=1.
REQ-021 Latency: out_valid rises the cycle after the closing beat is accepted.
REQ-022 HOLD with out_ready=1: go IDLE next cycle; in_ready rises that cycle (one-cycle bubble; no combinational path out_ready -> in_ready).
REQ-023 HOLD with out_ready=0: remain; in_data/in_valid ignored.
REQ-024 out_sum/out_ovf/out_count/out_trunc SHALL read 0 when out_valid=0.
REQ-025 count SHALL never exceed MAX_OPS; no wrap.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, acc=0, ovf=0, count=0, trunc=0, out_valid=0, in_ready=0 while asserted.
REQ-027 Reset mid-frame or in HOLD SHALL discard the frame; no result emitted after release.
REQ-028 in_ready SHALL be 1 from the first rising clk edge after rst_n deasserts.

Structure
REQ-029 Shared package accum_pkg SHALL hold the state enum (IDLE, ACCUM, HOLD), DATA_W=16, CNT_W=8.
REQ-030 17-bit add SHALL live in sub-module acc_add16 (a, b, ci=0 -> s[15:0], co), purely combinational.

Verification
REQ-031 Frame 0x0001,0x0002,0x0003(last) -> out_sum=0x0006, ovf=0, count=3, trunc=0, out_valid one cycle after last beat.
REQ-032 Frame 0xFFFF,0x0002(last) -> out_sum=0x0001, ovf=1, count=2.
REQ-033 MAX_OPS=4, 6 beats of 0x0010, no last -> result sum=0x0040, count=4, trunc=1; beats 5-6 held off by in_ready=0 until result consumed, then start new frame.
REQ-034 Single beat 0x1234 with last -> sum=0x1234, count=1; hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-035 Assert rst_n=0 after 2 beats of a frame -> outputs zero immediately; after release, frame 0x0005(last) -> sum=0x0005, count=1.
REQ-036 Back-to-back frames with in_valid constant 1 and out_ready=1 -> exactly one idle cycle between closing beat of one frame and first beat of next after HOLD.
